// File: rtl/bcd_countdown.sv
// rtl/bcd_countdown.sv - multi-digit BCD countdown timer with terminal-count borrow pulse
// Optional feature macro: BCD_COUNTDOWN_RELOAD_EN (auto-reload from the load value on terminal count)
module bcd_countdown #(
    parameter int DIGITS = 4
) (
    input  logic                clock,
    input  logic                reset_,
    input  logic                load,
    input  logic [4*DIGITS-1:0] din,
    input  logic                start,
    input  logic                stop,
    input  logic                ei,
    output logic [4*DIGITS-1:0] q,
    output logic                busy,
    output logic                done,
    output logic                bu
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           bu_q, bu_d;
    logic [W-1:0]   din_sat;
    logic [W-1:0]   cnt_dec;
    logic           dec_borrow;
    logic           reload_hit;
    logic [W-1:0]   reload_val;

`ifdef BCD_COUNTDOWN_RELOAD_EN
    logic [W-1:0]   reload_q, reload_d;

    // Auto-reload only applies when a non-zero start value was captured
    always_comb begin
        reload_hit = (reload_q != '0);
        reload_val = reload_q;
    end
`else
    // Without auto-reload the terminal count always lands in DONE
    always_comb begin
        reload_hit = 1'b0;
        reload_val = '0;
    end
`endif

    // Clamp each incoming digit to 9 so the counter only ever holds legal BCD
    always_comb begin
        din_sat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            din_sat[4*i +: 4] = (din[4*i +: 4] > 4'd9) ? 4'd9 : din[4*i +: 4];
        end
    end

    // BCD minus one: a zero digit becomes 9 and passes the borrow upward in the same cycle
    always_comb begin
        cnt_dec    = cnt_q;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dec_borrow) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    cnt_dec[4*i +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end

    // Next state, next count and the borrow pulse; priorities: load > stop > start, stop > ei
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bu_d    = 1'b0;
`ifdef BCD_COUNTDOWN_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    cnt_d = din_sat;
`ifdef BCD_COUNTDOWN_RELOAD_EN
                    reload_d = din_sat;
`endif
                end else if (start) begin
                    if (cnt_q != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                        bu_d    = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (ei) begin
                    if (cnt_dec == '0) begin
                        bu_d = 1'b1;
                        if (reload_hit) begin
                            cnt_d = reload_val;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
            end
            ST_DONE: begin
                if (load) begin
                    cnt_d   = din_sat;
                    state_d = ST_IDLE;
`ifdef BCD_COUNTDOWN_RELOAD_EN
                    reload_d = din_sat;
`endif
                end else if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    bu_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Registered state, count and decoded status outputs
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bu_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bu_q    <= bu_d;
        end
    end

`ifdef BCD_COUNTDOWN_RELOAD_EN
    // Start value remembered for auto-reload
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign q    = cnt_q;
    assign busy = busy_q;
    assign done = done_q;
    assign bu   = bu_q;

endmodule
